// File: rtl/fetch_pkg.sv
// Shared fetch/decode types and constants for the multicycle RV32I core.
package fetch_pkg;

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_t;

   localparam int ERR_MISALIGN = 0;
   localparam int ERR_TIMEOUT  = 1;
   localparam int ERR_ILLEGAL  = 2;
   localparam int ERR_SPURIOUS = 3;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   localparam logic [6:0] OPC_LUI      = 7'h37;
   localparam logic [6:0] OPC_AUIPC    = 7'h17;
   localparam logic [6:0] OPC_JAL      = 7'h6f;
   localparam logic [6:0] OPC_JALR     = 7'h67;
   localparam logic [6:0] OPC_BRANCH   = 7'h63;
   localparam logic [6:0] OPC_LOAD     = 7'h03;
   localparam logic [6:0] OPC_STORE    = 7'h23;
   localparam logic [6:0] OPC_OP_IMM   = 7'h13;
   localparam logic [6:0] OPC_OP       = 7'h33;
   localparam logic [6:0] OPC_MISC_MEM = 7'h0f;
   localparam logic [6:0] OPC_SYSTEM   = 7'h73;

   function automatic logic is_rv32i_opcode(input logic [6:0] opc);
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
         OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/riscv_field_decode.sv
// Pure combinational slicing of an RV32I instruction word into its fields.
module riscv_field_decode (
   input  logic [31:0] ir,
   output logic [6:0]  opcode,
   output logic [2:0]  funct3,
   output logic [6:0]  funct7,
   output logic [4:0]  rs1,
   output logic [4:0]  rs2,
   output logic [4:0]  rd
);

   assign opcode = ir[6:0];
   assign rd     = ir[11:7];
   assign funct3 = ir[14:12];
   assign rs1    = ir[19:15];
   assign rs2    = ir[24:20];
   assign funct7 = ir[31:25];

endmodule

// File: rtl/fetch_unit_v1.sv
// Instruction fetch FSM: PC, imem request/response, IR and decode handshake.
// Optional FETCH_PERF_CNT_EN adds saturating fetch/squash performance counters.
module fetch_unit_v1
   import fetch_pkg::*;
#(
   parameter int          XLEN           = 32,
   parameter logic [XLEN-1:0] RESET_PC   = '0,
   parameter int          TIMEOUT_CYCLES = 255
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_data,
   input  logic            pc_load_en,
   input  logic [XLEN-1:0] pc_load_value,
   output logic            dec_valid,
   input  logic            dec_ready,
   output logic [XLEN-1:0] dec_pc,
   output logic [31:0]     dec_instr,
   output logic [6:0]      opcode,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [1:0]      fetch_state_vector,
   output logic [7:0]      fetch_error_vector
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]     perf_fetch_count,
   output logic [31:0]     perf_squash_count
`endif
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   fetch_state_t    state;
   logic [XLEN-1:0] pc;
   logic [31:0]     ir;
   logic            squash;
   logic [3:0]      err;
   logic [TW-1:0]   tcnt;

   wire req_hs = (state == S_REQ) && imem_req_valid && imem_req_ready;
   // A response is dropped if a redirect is pending or arrives with it.
   wire rsp_drop = (state == S_WAIT) && imem_rsp_valid && (squash || pc_load_en);

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= S_REQ;
         pc             <= RESET_PC;
         ir             <= NOP_INSTR;
         dec_pc         <= RESET_PC;
         dec_valid      <= 1'b0;
         imem_req_valid <= 1'b0;
         squash         <= 1'b0;
         err            <= '0;
         tcnt           <= '0;
      end else begin
         if (imem_rsp_valid && state != S_WAIT) err[ERR_SPURIOUS] <= 1'b1;
         if (pc_load_en) begin
            pc <= {pc_load_value[XLEN-1:2], 2'b00};
            if (pc_load_value[1:0] != 2'b00) err[ERR_MISALIGN] <= 1'b1;
         end
         case (state)
            S_REQ: begin
               imem_req_valid <= 1'b1;
               if (req_hs) begin
                  state          <= S_WAIT;
                  imem_req_valid <= 1'b0;
                  tcnt           <= '0;
                  squash         <= pc_load_en;
               end
            end
            S_WAIT: begin
               if (tcnt != TW'(TIMEOUT_CYCLES)) tcnt <= tcnt + 1'b1;
               else err[ERR_TIMEOUT] <= 1'b1;
               if (rsp_drop) begin
                  squash         <= 1'b0;
                  state          <= S_REQ;
                  imem_req_valid <= 1'b1;
               end else if (imem_rsp_valid) begin
                  ir        <= imem_rsp_data;
                  dec_pc    <= pc;
                  dec_valid <= 1'b1;
                  state     <= S_HOLD;
                  if (imem_rsp_data[1:0] != 2'b11) err[ERR_ILLEGAL] <= 1'b1;
               end else if (pc_load_en) begin
                  squash <= 1'b1;
               end
            end
            S_HOLD: begin
               if (pc_load_en || dec_ready) begin
                  if (!pc_load_en) pc <= pc + XLEN'(4);
                  dec_valid      <= 1'b0;
                  imem_req_valid <= 1'b1;
                  state          <= S_REQ;
               end
            end
            default: begin
               state          <= S_REQ;
               dec_valid      <= 1'b0;
               imem_req_valid <= 1'b1;
               squash         <= 1'b0;
            end
         endcase
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_fetch_count  <= '0;
         perf_squash_count <= '0;
      end else begin
         if (dec_valid && dec_ready && !pc_load_en && perf_fetch_count != '1)
            perf_fetch_count <= perf_fetch_count + 1'b1;
         if (rsp_drop && perf_squash_count != '1)
            perf_squash_count <= perf_squash_count + 1'b1;
      end
   end
`endif

   assign imem_req_addr      = pc;
   assign dec_instr          = ir;
   assign fetch_state_vector = state;
   assign fetch_error_vector = {4'b0000, err};

   riscv_field_decode u_dec (
      .ir     (ir),
      .opcode (opcode),
      .funct3 (funct3),
      .funct7 (funct7),
      .rs1    (rs1),
      .rs2    (rs2),
      .rd     (rd)
   );

endmodule

// File: tb/tb_fetch_unit_v1.sv
// Self-checking bench for fetch_unit_v1: table-driven fetches plus redirect,
// timeout, spurious-response and mid-transaction reset sequences.
module tb_fetch_unit_v1;

   logic        clk = 1'b0;
   logic        rst;
   logic        imem_req_valid, imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        pc_load_en;
   logic [31:0] pc_load_value;
   logic        dec_valid, dec_ready;
   logic [31:0] dec_pc, dec_instr;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic [4:0]  rs1, rs2, rd;
   logic [1:0]  fetch_state_vector;
   logic [7:0]  fetch_error_vector;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_fetch_count, perf_squash_count;
`endif

   always #5 clk = ~clk;

   fetch_unit_v1 dut (
      .clk(clk), .rst(rst),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .pc_load_en(pc_load_en),
      .pc_load_value(pc_load_value), .dec_valid(dec_valid), .dec_ready(dec_ready),
      .dec_pc(dec_pc), .dec_instr(dec_instr), .opcode(opcode), .funct3(funct3),
      .funct7(funct7), .rs1(rs1), .rs2(rs2), .rd(rd),
      .fetch_state_vector(fetch_state_vector),
      .fetch_error_vector(fetch_error_vector)
`ifdef FETCH_PERF_CNT_EN
      , .perf_fetch_count(perf_fetch_count), .perf_squash_count(perf_squash_count)
`endif
   );

   typedef struct {
      logic [31:0] word;
      logic [6:0]  opc;
      logic [4:0]  rd;
      logic [2:0]  f3;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [6:0]  f7;
   } vec_t;

   typedef struct {
      vec_t        v;
      logic [31:0] pc;
   } exp_t;

   vec_t vecs[5];
   exp_t sb[$];
   int total = 0;
   int bad = 0;
   logic [31:0] mpc;
   int nfetch = 0;
   logic ill_seen = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_req();
      int n = 0;
      while (!imem_req_valid && n < 50) begin step(); n++; end
      total++;
      if (!imem_req_valid) begin bad++; $display("FAIL wait_req: no request after %0d cycles", n); end
   endtask

   task automatic wait_dec();
      int n = 0;
      while (!dec_valid && n < 50) begin step(); n++; end
      total++;
      if (!dec_valid) begin bad++; $display("FAIL wait_dec: no dec_valid after %0d cycles", n); end
   endtask

   // Request handshake then response one cycle later; leaves FSM in S_HOLD.
   task automatic fetch_to_hold(input vec_t v);
      exp_t e;
      wait_req();
      chk("req_addr", imem_req_addr, mpc);
      imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
      e.v = v; e.pc = mpc; sb.push_back(e);
      imem_rsp_valid = 1'b1; imem_rsp_data = v.word; step(); imem_rsp_valid = 1'b0;
      if (v.word[1:0] != 2'b11) ill_seen = 1'b1;
   endtask

   task automatic check_dec();
      exp_t e;
      wait_dec();
      if (sb.size() == 0) begin
         total++; bad++; $display("FAIL scoreboard: empty at dec_valid");
      end else begin
         e = sb.pop_front();
         chk("dec_instr", dec_instr, e.v.word);
         chk("dec_pc", dec_pc, e.pc);
         chk("fields", {opcode, rd, funct3, rs1, rs2, funct7},
             {e.v.opc, e.v.rd, e.v.f3, e.v.rs1, e.v.rs2, e.v.f7});
         chk("err_illegal", 32'(fetch_error_vector[2]), 32'(ill_seen));
      end
   endtask

   task automatic accept();
      dec_ready = 1'b1; step(); dec_ready = 1'b0;
      mpc = mpc + 4; nfetch++;
   endtask

   initial begin
      vec_t tv;
      vecs[0] = '{32'h00500093, 7'h13, 5'd1, 3'd0, 5'd0, 5'd5, 7'h00};
      vecs[1] = '{32'h002081B3, 7'h33, 5'd3, 3'd0, 5'd1, 5'd2, 7'h00};
      vecs[2] = '{32'h40315233, 7'h33, 5'd4, 3'd5, 5'd2, 5'd3, 7'h20};
      vecs[3] = '{32'h00000000, 7'h00, 5'd0, 3'd0, 5'd0, 5'd0, 7'h00};
      vecs[4] = '{32'hFFFFFFFF, 7'h7f, 5'h1f, 3'd7, 5'h1f, 5'h1f, 7'h7f};

      rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
      pc_load_en = 1'b0; pc_load_value = '0; dec_ready = 1'b0;
      repeat (3) step();
      chk("rst_state", 32'(fetch_state_vector), 32'd0);
      chk("rst_dec_valid", 32'(dec_valid), 32'd0);
      chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_err", 32'(fetch_error_vector), 32'd0);
      chk("rst_instr", dec_instr, 32'h13);
      chk("rst_opcode", 32'(opcode), 32'h13);
      chk("rst_dec_pc", dec_pc, 32'd0);
      rst = 1'b0;
      mpc = 32'h0;

      for (int i = 0; i < 5; i++) begin
         fetch_to_hold(vecs[i]);
         check_dec();
         accept();
      end

      // Redirect while waiting: response must be discarded.
      wait_req();
      imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
      pc_load_en = 1'b1; pc_load_value = 32'h100; step(); pc_load_en = 1'b0;
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEADBEEF; step(); imem_rsp_valid = 1'b0;
      chk("squash_dec_valid", 32'(dec_valid), 32'd0);
      chk("squash_state", 32'(fetch_state_vector), 32'd0);
      mpc = 32'h100;
      wait_req();
      chk("squash_addr", imem_req_addr, 32'h100);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_squash", perf_squash_count, 32'd1);
      chk("perf_fetch", perf_fetch_count, 32'(nfetch));
`endif

      // Misaligned redirect in S_HOLD with dec_ready: no +4.
      tv = vecs[0];
      fetch_to_hold(tv);
      check_dec();
      pc_load_en = 1'b1; pc_load_value = 32'h102; dec_ready = 1'b1; step();
      pc_load_en = 1'b0; dec_ready = 1'b0;
      chk("hold_redir_dec_valid", 32'(dec_valid), 32'd0);
      chk("misalign_err", 32'(fetch_error_vector[0]), 32'd1);
      mpc = 32'h100;
      wait_req();
      chk("hold_redir_addr", imem_req_addr, 32'h100);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_fetch_cancel", perf_fetch_count, 32'(nfetch));
`endif

      // Stalled request, then a long response delay hitting the timeout.
      for (int i = 0; i < 3; i++) begin
         chk("stall_valid", 32'(imem_req_valid), 32'd1);
         chk("stall_addr", imem_req_addr, 32'h100);
         step();
      end
      imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
      sb.push_back('{vecs[1], 32'h100});
      repeat (200) step();
      chk("timeout_early", 32'(fetch_error_vector[1]), 32'd0);
      chk("timeout_state", 32'(fetch_state_vector), 32'd1);
      repeat (100) step();
      chk("timeout_set", 32'(fetch_error_vector[1]), 32'd1);
      chk("timeout_still_wait", 32'(fetch_state_vector), 32'd1);
      imem_rsp_valid = 1'b1; imem_rsp_data = vecs[1].word; step(); imem_rsp_valid = 1'b0;
      check_dec();
      accept();

      // Spurious response during S_HOLD must not touch IR.
      fetch_to_hold(vecs[3]);
      check_dec();
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h12345678; step(); imem_rsp_valid = 1'b0;
      chk("spurious_err", 32'(fetch_error_vector[3]), 32'd1);
      chk("spurious_instr", dec_instr, 32'h0);
      chk("spurious_hold", 32'(dec_valid), 32'd1);
      accept();

      // Reset during S_WAIT; late response afterwards counts as spurious.
      wait_req();
      imem_req_ready = 1'b1; step(); imem_req_ready = 1'b0;
      chk("pre_rst_state", 32'(fetch_state_vector), 32'd1);
      rst = 1'b1; step(); rst = 1'b0;
      chk("mid_rst_state", 32'(fetch_state_vector), 32'd0);
      chk("mid_rst_dec_valid", 32'(dec_valid), 32'd0);
      chk("mid_rst_err", 32'(fetch_error_vector), 32'd0);
      chk("mid_rst_addr", imem_req_addr, 32'd0);
      imem_rsp_valid = 1'b1; imem_rsp_data = 32'h00500093; step(); imem_rsp_valid = 1'b0;
      chk("late_rsp_err", 32'(fetch_error_vector), 32'h08);
      chk("late_rsp_dec_valid", 32'(dec_valid), 32'd0);
      wait_req();
      chk("post_rst_addr", imem_req_addr, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fetch_unit_v1.md
Name: fetch_unit_v1

Overview:
Instruction-fetch and decode stage directly upstream of controller_v1 in the multicycle RV32I core. Holds the PC and issues instruction-memory reads over a valid/ready request channel with a valid-only response. Latches the returned word into an instruction register and presents opcode/funct3/funct7/register fields to the controller through a valid/ready handshake. Accepts PC redirects from the controller for branches and jumps, and reports faults on a sticky error vector.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset
TIMEOUT_CYCLES, 255, S_WAIT cycles before the timeout error flags (counter width = $clog2(TIMEOUT_CYCLES+1))

Ports:
clk  input  1  core clock
rst  input  1  synchronous active-high reset
imem_req_valid  output  1  read request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  XLEN  word-aligned fetch address (= pc)
imem_rsp_valid  input  1  read data valid (no backpressure)
imem_rsp_data  input  32  instruction word
pc_load_en  input  1  redirect strobe from controller
pc_load_value  input  XLEN  redirect target
dec_valid  output  1  decoded instruction valid
dec_ready  input  1  controller accepts instruction
dec_pc  output  XLEN  PC of presented instruction
dec_instr  output  32  raw instruction register
opcode  output  7  IR[6:0]
funct3  output  3  IR[14:12]
funct7  output  7  IR[31:25]
rs1  output  5  IR[19:15]
rs2  output  5  IR[24:20]
rd  output  5  IR[11:7]
fetch_state_vector  output  2  current FSM state encoding
fetch_error_vector  output  8  sticky error flags

Behaviour:
- Clock and reset: one clock clk; rst is synchronous and active-high.
- Reset values: pc=RESET_PC; IR=32'h0000_0013 (NOP), so opcode=7'h13 and the other fields follow from the NOP; dec_pc=RESET_PC; dec_valid=0; imem_req_valid=0; state=S_REQ; squash=0; error vector=0; timeout counter=0.
- Outputs are registered or derived combinationally from registers only; no input-to-output combinational path.
- States: S_REQ=2'd0, S_WAIT=2'd1, S_HOLD=2'd2. Encoding 2'd3 is unreachable and recovers to S_REQ.
- S_REQ: imem_req_valid=1, imem_req_addr=pc. When imem_req_ready=1, go to S_WAIT and clear the timeout counter.
- S_WAIT: when imem_rsp_valid=1 and squash=0, load IR<=imem_rsp_data and dec_pc<=pc, then go to S_HOLD. When imem_rsp_valid=1 and squash=1, discard the data, clear squash, and go to S_REQ.
- S_HOLD: dec_valid=1. When dec_ready=1, pc<=pc+4 (wraps modulo 2^XLEN) and go to S_REQ.
- Minimum throughput: 3 cycles per instruction. Example: request handshake at cycle N, response at N+1, dec_valid high at N+2, dec handshake at N+2, next request at N+3.
- Redirect (pc_load_en=1) takes priority over everything else in every state. pc<=pc_load_value with bits [1:0] forced to 0.
  - In S_REQ with a request handshake in the same cycle: go to S_WAIT with squash=1.
  - In S_REQ without a handshake: stay in S_REQ; the new address appears the next cycle.
  - In S_WAIT: set squash=1. If the response arrives in the same cycle, drop it and go to S_REQ.
  - In S_HOLD: dec_valid drops the next cycle and the FSM goes to S_REQ. A simultaneous dec_ready does not add 4.
- fetch_error_vector bits (all sticky, cleared only by rst):
  - [0] redirect target misaligned (pc_load_value[1:0]!=0)
  - [1] S_WAIT counter reached TIMEOUT_CYCLES; the FSM keeps waiting
  - [2] latched instruction has IR[1:0]!=2'b11; the instruction is still presented
  - [3] imem_rsp_valid=1 outside S_WAIT; the data is ignored
  - [7:4] always 0
- rst asserted mid-transaction returns everything to reset values next cycle. Any in-flight memory response arriving after reset is ignored and sets bit [3].

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds output ports perf_fetch_count[31:0] and perf_squash_count[31:0], both reset to 0.
  - perf_fetch_count increments on every dec_valid&&dec_ready handshake that is not cancelled by a redirect.
  - perf_squash_count increments on every discarded response.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - fetch_state_t enum (S_REQ, S_WAIT, S_HOLD)
  - error bit index constants ERR_MISALIGN=0, ERR_TIMEOUT=1, ERR_ILLEGAL=2, ERR_SPURIOUS=3
  - NOP_INSTR=32'h0000_0013
  - RV32I opcode localparams shared with controller_v1
- One combinational sub-module, riscv_field_decode, slices IR into the opcode, funct, and register fields.

Test Plan:
- Reset, then ready=1 and a 1-cycle response with 32'h00500093: imem_req_addr=0, dec_valid at cycle 2, opcode=7'h13, rd=1, rs1=0, funct3=0; after dec_ready, next imem_req_addr=4.
- Redirect to 32'h0000_0100 while in S_WAIT, then a response of 32'hDEADBEEF: response discarded, dec_valid stays 0, next request address=32'h100 (with FETCH_PERF_CNT_EN: perf_squash_count=1).
- pc_load_en with 32'h0000_0102 in S_HOLD together with dec_ready=1: next address=32'h100, not 32'h104; fetch_error_vector[0]=1.
- imem_req_ready held low for 3 cycles, then response delayed 300 cycles: request stays asserted with a stable address; error bit [1] sets at cycle 255 of S_WAIT; the instruction is still delivered.
- Response 32'h00000000 and a spurious imem_rsp_valid in S_HOLD: bits [2] and [3] set; dec_instr is unchanged by the spurious pulse.
- rst asserted during S_WAIT: next cycle state=S_REQ, pc=RESET_PC, dec_valid=0, error vector=0.
